// File: rtl/sync_gen_pulser.sv
// sync_gen_pulser
// Turns the sync_gen software control word into the design-wide sync pulse.
// The pulse is a single shot or periodic, and fires either directly from a
// software arm edge or from the next external PPS/trigger edge after arming.
//
// Ports:
//   user_clk     - sole clock
//   user_rst_n   - asynchronous active-low reset
//   ctrl_in      - [0] arm (rising edge), [1] periodic, [2] source (1 = ext),
//                  [3] stop, [4] count clear, [7:5] reserved, [31:8] period P
//   ext_sync_in  - asynchronous external trigger / PPS
//   sync_out     - registered sync pulse, PULSE_LEN cycles wide
//   busy         - state is not IDLE
//   armed        - waiting for the external edge
//   sync_count   - pulses started since reset or count clear (wraps)
module sync_gen_pulser #(
  parameter int PULSE_LEN = 4,
  parameter int PERIOD_W  = 24,
  parameter int CNT_W     = 32
) (
  input  logic             user_clk,
  input  logic             user_rst_n,
  input  logic [31:0]      ctrl_in,
  input  logic             ext_sync_in,
  output logic             sync_out,
  output logic             busy,
  output logic             armed,
  output logic [CNT_W-1:0] sync_count
);

  typedef enum logic [1:0] {IDLE, WAIT_EXT, PULSE, GAP} state_t;

  localparam logic [PERIOD_W-1:0] PLEN  = PERIOD_W'(PULSE_LEN);
  localparam logic [PERIOD_W-1:0] PLAST = PERIOD_W'(PULSE_LEN - 1);

  // A period shorter than the pulse would leave no low cycle between pulses.
  function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
    return (p < PLEN) ? PLEN : p;
  endfunction

  state_t state, next_state;

  logic [31:0]         ctrl_q;
  logic                arm_q2;
  logic                first_q;
  logic                s1, s2, s3;
  logic                ext_edge_q;
  logic [PERIOD_W-1:0] ivl_cnt;
  logic [PERIOD_W-1:0] pe_q;

  logic arm_edge, ext_edge, stop, periodic, src, cnt_clr, pulse_start;
  logic unused_rsvd;

  assign unused_rsvd = ^ctrl_q[7:5];

  assign arm_edge = ctrl_q[0] & ~arm_q2 & ~first_q;
  assign ext_edge = s2 & ~s3;
  assign periodic = ctrl_q[1];
  assign src      = ctrl_q[2];
  assign stop     = ctrl_q[3];
  assign cnt_clr  = ctrl_q[4];

  // Control word capture, arm-edge history and ext synchroniser.
  // On the first clock after reset the edge history is loaded with the same
  // sample as ctrl_q, so an arm bit already high at reset release never
  // looks like a rising edge.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ctrl_q     <= '0;
      arm_q2     <= 1'b0;
      first_q    <= 1'b1;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      ext_edge_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_in;
      arm_q2     <= first_q ? ctrl_in[0] : ctrl_q[0];
      first_q    <= 1'b0;
      s1         <= ext_sync_in;
      s2         <= s1;
      s3         <= s2;
      // Registered edge gives the 4-edge external latency.
      ext_edge_q <= ext_edge;
    end
  end

  // State register
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) state <= IDLE;
    else             state <= next_state;
  end

  // Next-state logic; stop overrides everything including a fresh arm edge.
  always_comb begin
    next_state = state;
    if (stop) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:     if (arm_edge) next_state = src ? WAIT_EXT : PULSE;
        WAIT_EXT: if (ext_edge_q) next_state = PULSE;
        PULSE:    if (ivl_cnt == PLAST) next_state = periodic ? GAP : IDLE;
        GAP: begin
          if (!periodic)           next_state = IDLE;
          else if (ivl_cnt == pe_q) next_state = PULSE;
        end
        default:  next_state = IDLE;
      endcase
    end
  end

  // Output decode from the next state so outputs register with the state.
  assign pulse_start = (next_state == PULSE) && (state != PULSE);

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      sync_out   <= 1'b0;
      busy       <= 1'b0;
      armed      <= 1'b0;
      sync_count <= '0;
      ivl_cnt    <= '0;
    end else begin
      sync_out <= (next_state == PULSE);
      busy     <= (next_state != IDLE);
      armed    <= (next_state == WAIT_EXT);
      // Interval counter is 0 on the first pulse cycle; next pulse at == pe_q.
      ivl_cnt  <= pulse_start ? '0 : ivl_cnt + 1'b1;
      if (cnt_clr)          sync_count <= '0;
      else if (pulse_start) sync_count <= sync_count + 1'b1;
    end
  end

  // Period latched at each pulse start; mid-interval writes apply next pulse.
  always_ff @(posedge user_clk) begin
    if (pulse_start) pe_q <= clamp_period(ctrl_q[8 +: PERIOD_W]);
  end

endmodule

// File: tb/tb_sync_gen_pulser.sv
module tb_sync_gen_pulser;

  localparam int PULSE_LEN = 4;
  localparam int CNT_W     = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      ctrl_in;
  logic             ext_sync_in;
  logic             sync_out;
  logic             busy;
  logic             armed;
  logic [CNT_W-1:0] sync_count;

  sync_gen_pulser #(.PULSE_LEN(PULSE_LEN), .PERIOD_W(24), .CNT_W(CNT_W)) dut (
    .user_clk    (clk),
    .user_rst_n  (rst_n),
    .ctrl_in     (ctrl_in),
    .ext_sync_in (ext_sync_in),
    .sync_out    (sync_out),
    .busy        (busy),
    .armed       (armed),
    .sync_count  (sync_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {int start; int width;} exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse monitor: pops expected start cycle and width per observed pulse.
  logic prev_so  = 1'b0;
  bit   in_pulse = 1'b0;
  int   cur_w    = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (sync_out && !prev_so) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_pulse: observed start=%0d expected none", cyc);
        in_pulse = 1'b0;
      end else begin
        cur = sb.pop_front();
        chk("pulse_start", cyc, cur.start);
        in_pulse = 1'b1;
        cur_w = 1;
      end
    end else if (sync_out) begin
      cur_w++;
    end else if (prev_so && in_pulse) begin
      chk("pulse_width", cur_w, cur.width);
      in_pulse = 1'b0;
    end
    prev_so = sync_out;
  end

  task automatic run_periodic(input logic [31:0] word, input int n, input int per);
    int s0;
    s0 = cyc + 2;
    for (int k = 0; k < n; k++) sb.push_back('{s0 + per * k, PULSE_LEN});
    ctrl_in = word;
    while (cyc < s0 + per * (n - 1)) @(negedge clk);
    ctrl_in = word & ~32'h2;
    tick(8);
    ctrl_in = 32'h0;
    tick(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, m, s0, s5;
    rst_n = 1'b0;
    ctrl_in = 32'h0;
    ext_sync_in = 1'b0;
    tick(3);
    chk("rst_sync_out", sync_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_armed", armed, 0);
    chk("rst_count", sync_count, 0);
    rst_n = 1'b1;
    tick(3);

    // Software single shot
    sb.push_back('{cyc + 2, PULSE_LEN});
    ctrl_in = 32'h1;
    tick(1);
    ctrl_in = 32'h0;
    tick(1);
    chk("single_busy_hi", busy, 1);
    tick(6);
    chk("single_busy_lo", busy, 0);
    chk("single_count", sync_count, 1);

    // Count clear
    ctrl_in = 32'h10;
    tick(2);
    chk("clear_count", sync_count, 0);
    ctrl_in = 32'h0;
    tick(2);

    // Periodic P=10, then reprogrammed to P=2 (clamped to 4)
    s0 = cyc + 2;
    for (int k = 0; k < 5; k++) sb.push_back('{s0 + 11 * k, PULSE_LEN});
    ctrl_in = 32'h0000_0A03;
    while (cyc < s0 + 44 + 1) @(negedge clk);
    ctrl_in = 32'h0000_0203;
    s5 = s0 + 55;
    sb.push_back('{s5, PULSE_LEN});
    for (int k = 1; k <= 94; k++) sb.push_back('{s5 + 5 * k, PULSE_LEN});
    while (cyc < s5 + 5 * 94) @(negedge clk);
    ctrl_in = 32'h0000_0201;
    tick(8);
    chk("periodic_count100", sync_count, 100);
    chk("periodic_idle", busy, 0);
    ctrl_in = 32'h0;
    tick(3);

    // External arm; ext activity before arming must be ignored
    ext_sync_in = 1'b1;
    tick(3);
    ext_sync_in = 1'b0;
    tick(6);
    chk("pre_arm_armed", armed, 0);
    chk("pre_arm_busy", busy, 0);
    ctrl_in = 32'h5;
    tick(4);
    chk("ext_armed", armed, 1);
    chk("ext_busy", busy, 1);
    chk("ext_no_pulse", sync_out, 0);
    m = cyc;
    sb.push_back('{m + 4, PULSE_LEN});
    ext_sync_in = 1'b1;
    tick(4);
    chk("ext_armed_drop", armed, 0);
    chk("ext_sync_hi", sync_out, 1);
    ext_sync_in = 1'b0;
    ctrl_in = 32'h0;
    tick(6);
    chk("ext_count", sync_count, 101);
    chk("ext_idle", busy, 0);

    // Stop during the 2nd pulse cycle truncates the pulse
    n = cyc;
    sb.push_back('{n + 2, 2});
    ctrl_in = 32'h1;
    tick(2);
    ctrl_in = 32'h9;
    tick(2);
    chk("stop_sync_lo", sync_out, 0);
    chk("stop_idle", busy, 0);
    ctrl_in = 32'h0;
    tick(3);

    // Arm and stop together: no pulse
    ctrl_in = 32'h9;
    tick(4);
    chk("armstop_busy", busy, 0);
    chk("armstop_sync", sync_out, 0);
    ctrl_in = 32'h1;
    tick(2);
    ctrl_in = 32'h0;
    tick(3);
    chk("armstop_count", sync_count, 102);

    // Arm held high through reset release: no pulse
    rst_n = 1'b0;
    ctrl_in = 32'h1;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("held_arm_busy", busy, 0);
    chk("held_arm_count", sync_count, 0);
    ctrl_in = 32'h0;
    tick(3);

    // Asynchronous reset in the middle of a GAP
    n = cyc;
    sb.push_back('{n + 2, PULSE_LEN});
    ctrl_in = 32'h0000_1403;
    tick(10);
    chk("gap_busy", busy, 1);
    chk("gap_sync_lo", sync_out, 0);
    chk("gap_count", sync_count, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sync", sync_out, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_armed", armed, 0);
    chk("async_rst_count", sync_count, 0);
    ctrl_in = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);

    // Count to all-ones, clear wins over simultaneous increment, then wrap
    run_periodic(32'h3, 255, 5);
    chk("count_full", sync_count, 255);
    sb.push_back('{cyc + 2, PULSE_LEN});
    ctrl_in = 32'h11;
    tick(8);
    chk("clear_beats_inc", sync_count, 0);
    ctrl_in = 32'h0;
    tick(3);
    run_periodic(32'h3, 255, 5);
    chk("count_full2", sync_count, 255);
    sb.push_back('{cyc + 2, PULSE_LEN});
    ctrl_in = 32'h1;
    tick(8);
    chk("count_wrap", sync_count, 0);
    ctrl_in = 32'h0;
    tick(5);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
